// File: rtl/vpu_top.sv
// vpu_top: single-issue register-to-register ALU core with 32x16 GPR file and IR
module vpu_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_in,
  input  logic        ir_load,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] sgpr,
  output logic        done
);
  logic [31:0] IR;
  logic [15:0] GPR [0:31];
  logic        pending;
  logic [4:0]  oper_type, rdst, rsrc1, rsrc2;
  logic        imm_mode;
  logic [15:0] isrc, op_a, op_b, result;
  logic [31:0] prod;
  logic        wr_en;
  assign oper_type = IR[31:27];
  assign rdst      = IR[26:22];
  assign rsrc1     = IR[21:17];
  assign imm_mode  = IR[16];
  assign rsrc2     = IR[15:11];
  assign isrc      = IR[15:0];
  assign op_a      = GPR[rsrc1];
  assign op_b      = imm_mode ? isrc : GPR[rsrc2];
  assign prod      = {16'b0, op_a} * {16'b0, op_b};
  assign wr_en     = pending && (oper_type <= 5'd11);
  assign rd_data   = GPR[rd_addr];
  always_comb begin
    result = '0;
    case (oper_type)
      5'd0:    result = sgpr;
      5'd1:    result = imm_mode ? isrc : op_a;
      5'd2:    result = op_a + op_b;
      5'd3:    result = op_a - op_b;
      5'd4:    result = prod[15:0];
      5'd5:    result = op_a | op_b;
      5'd6:    result = op_a & op_b;
      5'd7:    result = op_a ^ op_b;
      5'd8:    result = ~(op_a ^ op_b);
      5'd9:    result = ~(op_a & op_b);
      5'd10:   result = ~(op_a | op_b);
      5'd11:   result = ~op_b;
      default: result = '0;
    endcase
  end
  // Sources are read combinationally from the pre-edge GPR contents, so rdst may alias a source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR      <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      sgpr    <= '0;
      for (int i = 0; i < 32; i++) GPR[i] <= '0;
    end else begin
      if (ir_load) IR <= ir_in;
      pending <= ir_load;
      done    <= wr_en;
      if (wr_en) GPR[rdst] <= result;
      if (wr_en && oper_type == 5'd4) sgpr <= prod[31:16];
    end
  end
endmodule

// File: tb/tb_vpu_top.sv
// tb_vpu_top: directed stimulus with a queue-based instruction model checked every cycle
module tb_vpu_top;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] ir_in = '0;
  logic        ir_load = 0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] rd_data, sgpr;
  logic        done;
  int total = 0, bad = 0, done_cnt = 0;

  vpu_top dut (.clk(clk), .rst_n(rst_n), .ir_in(ir_in), .ir_load(ir_load),
               .rd_addr(rd_addr), .rd_data(rd_data), .sgpr(sgpr), .done(done));

  always #5 clk = ~clk;

  logic [31:0] m_q[$];
  logic [15:0] m_gpr[32];
  logic [15:0] m_sgpr;
  logic        m_done;

  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(int op, int rd, int rs1, int im, logic [15:0] lo);
    return {op[4:0], rd[4:0], rs1[4:0], im[0], lo};
  endfunction

  function automatic logic [31:0] encr(int op, int rd, int rs1, int rs2);
    return {op[4:0], rd[4:0], rs1[4:0], 1'b0, rs2[4:0], 11'b0};
  endfunction

  task automatic model_exec(logic [31:0] ir);
    int unsigned op, a, b, p, r;
    op = ir[31:27];
    a = m_gpr[ir[21:17]];
    b = ir[16] ? ir[15:0] : m_gpr[ir[15:11]];
    p = a * b;
    r = 0;
    case (op)
      0: r = m_sgpr;
      1: r = ir[16] ? ir[15:0] : a;
      2: r = a + b;
      3: r = a - b;
      4: r = p;
      5: r = a | b;
      6: r = a & b;
      7: r = a ^ b;
      8: r = ~(a ^ b);
      9: r = ~(a & b);
      10: r = ~(a | b);
      11: r = ~b;
      default: r = 0;
    endcase
    if (op <= 11) begin
      m_gpr[ir[26:22]] = r[15:0];
      if (op == 4) m_sgpr = p[31:16];
      m_done = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = {};
      foreach (m_gpr[i]) m_gpr[i] = '0;
      m_sgpr = '0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_q.size() > 0) model_exec(m_q.pop_front());
      if (ir_load) m_q.push_back(ir_in);
    end
  end

  always @(posedge clk) begin
    int k;
    #2;
    k = int'(rd_addr);
    for (int i = 31; i >= 0; i--) if (dut.GPR[i] !== m_gpr[i]) k = i;
    check($sformatf("gpr[%0d]", k), dut.GPR[k], m_gpr[k]);
    check("sgpr", sgpr, m_sgpr);
    check("done", done, m_done);
    check("rd_data", rd_data, m_gpr[rd_addr]);
    if (done) done_cnt++;
  end

  initial forever begin
    @(negedge clk);
    rd_addr = rd_addr + 5'd1;
  end

  task automatic issue(logic [31:0] ir);
    @(negedge clk);
    ir_in = ir;
    ir_load = 1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      ir_load = 0;
    end
  endtask

  initial begin
    #2;
    check("reset_ir", dut.IR, 32'h0);
    check("reset_done", done, 1'b0);
    check("reset_sgpr", sgpr, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 32; i++) issue(enc(1, i, 0, 1, 16'd2));
    idle(2);
    check("preset_gpr31", dut.GPR[31], 16'd2);
    done_cnt = 0;
    issue(enc(2, 0, 2, 1, 16'd4));
    idle(3);
    check("add_imm", dut.GPR[0], 16'd6);
    check("add_imm_done_once", done_cnt, 1);
    issue(encr(2, 0, 4, 5));
    idle(2);
    check("add_reg", dut.GPR[0], 16'd4);
    issue(enc(1, 4, 0, 1, 16'd55));
    idle(2);
    check("movi", dut.GPR[4], 16'd55);
    issue(enc(1, 4, 7, 0, 16'd0));
    idle(2);
    check("mov", dut.GPR[4], 16'd2);
    issue(enc(1, 1, 0, 1, 16'h1234));
    issue(enc(4, 3, 1, 1, 16'h0100));
    issue(enc(0, 9, 0, 0, 16'h0));
    idle(2);
    check("mul_lo", dut.GPR[3], 16'h3400);
    check("mul_hi", sgpr, 16'h0012);
    check("movsgpr", dut.GPR[9], 16'h0012);
    issue(enc(1, 10, 0, 1, 16'hFFFF));
    issue(enc(2, 11, 10, 1, 16'd1));
    issue(enc(1, 12, 0, 1, 16'h0));
    issue(enc(3, 13, 12, 1, 16'd1));
    issue(enc(11, 14, 0, 1, 16'h00FF));
    idle(2);
    check("add_wrap", dut.GPR[11], 16'h0000);
    check("sub_wrap", dut.GPR[13], 16'hFFFF);
    check("rnot", dut.GPR[14], 16'hFF00);
    issue(enc(1, 15, 0, 1, 16'd7));
    issue(enc(2, 16, 15, 1, 16'd1));
    issue(encr(2, 15, 15, 15));
    idle(2);
    check("dependent", dut.GPR[16], 16'd8);
    check("self_src", dut.GPR[15], 16'd14);
    issue(enc(5, 17, 5, 1, 16'h0101));
    issue(enc(6, 21, 5, 1, 16'd3));
    issue(enc(7, 22, 5, 1, 16'd3));
    issue(enc(8, 18, 5, 1, 16'd3));
    issue(enc(9, 19, 5, 1, 16'd3));
    issue(enc(10, 20, 5, 1, 16'd1));
    idle(2);
    check("ror", dut.GPR[17], 16'h0103);
    check("rand", dut.GPR[21], 16'h0002);
    check("rxor", dut.GPR[22], 16'h0001);
    check("rxnor", dut.GPR[18], 16'hFFFE);
    check("rnand", dut.GPR[19], 16'hFFFD);
    check("rnor", dut.GPR[20], 16'hFFFC);
    done_cnt = 0;
    issue(enc(20, 0, 5, 1, 16'h1111));
    idle(3);
    check("nop_gpr", dut.GPR[0], 16'd4);
    check("nop_done", done_cnt, 0);
    issue(enc(2, 23, 5, 1, 16'd5));
    @(negedge clk);
    ir_load = 0;
    rst_n = 0;
    #1;
    check("rst_ir", dut.IR, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_gpr23", dut.GPR[23], 16'h0);
    check("rst_gpr0", dut.GPR[0], 16'h0);
    @(negedge clk);
    rst_n = 1;
    idle(2);
    check("rst_no_wb", dut.GPR[23], 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
